// File: rtl/mtr_drv_pkg.sv
// Shared types, defaults and the speed-to-duty mapping for the motor-drive stage.
package mtr_drv_pkg;

  // PWM counter width; the period is 2^CNT_W clocks and the duty mapping
  // below produces exactly this many bits from a 12-bit command.
  localparam int CNT_W           = 11;

  localparam int DEAD_T_DEF      = 32;
  localparam int BLANK_T_DEF     = 128;
  localparam int OVR_I_LIMIT_DEF = 8;

  // Duty value for a zero speed command (50%).
  localparam logic [CNT_W-1:0] DUTY_MID = 11'h400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Signed command to offset-binary duty: (spd >>> 1) + 0x400.
  function automatic logic [CNT_W-1:0] spd2duty(input logic signed [11:0] spd);
    return {~spd[11], spd[10:1]};
  endfunction

endpackage

// File: rtl/mtr_drv_pwm_deadtime.sv
// One H-bridge leg: dead-time insertion on the raw PWM and high-side on-time
// tracking used to blank the over-current comparator after turn-on.
module pwm_deadtime
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_T  = DEAD_T_DEF,
  parameter int BLANK_T = BLANK_T_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_raw,
  input  logic force_off,
  output logic PWM1,
  output logic PWM2,
  output logic hs_qual
);

  localparam int DT_W = $clog2(DEAD_T + 1);
  localparam int BL_W = $clog2(BLANK_T + 1);
  localparam logic [DT_W-1:0] DT_MAX = DT_W'(DEAD_T);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLANK_T);

  logic            r_raw_d;
  logic [DT_W-1:0] r_dt;
  logic [BL_W-1:0] r_on;
  logic            w_edge;
  logic [DT_W-1:0] w_dt;
  logic            w_dt_ok;

  // The edge cycle itself counts as dead-time cycle 0, so exactly DEAD_T
  // cycles after every raw edge are masked.
  assign w_edge  = pwm_raw ^ r_raw_d;
  assign w_dt    = w_edge ? '0 : r_dt;
  assign w_dt_ok = (w_dt >= DT_MAX);

  // Dead-time counter: restart on each raw edge, saturate at DEAD_T.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_raw_d <= 1'b0;
      r_dt    <= '0;
    end else begin
      r_raw_d <= pwm_raw;
      r_dt    <= (w_dt < DT_MAX) ? w_dt + DT_W'(1) : w_dt;
    end
  end

  // Registered gate drives; both are gated by the same dead-time qualifier so
  // they can never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      PWM1 <= 1'b0;
      PWM2 <= 1'b0;
    end else begin
      PWM1 <= ~force_off &  pwm_raw & w_dt_ok;
      PWM2 <= ~force_off & ~pwm_raw & w_dt_ok;
    end
  end

  // High-side on-time: counts while PWM1 is on, clears while it is off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_on <= '0;
    end else if (!PWM1) begin
      r_on <= '0;
    end else if (r_on < BL_MAX) begin
      r_on <= r_on + BL_W'(1);
    end
  end

  assign hs_qual = PWM1 & (r_on >= BL_MAX);

endmodule

// File: rtl/mtr_drv.sv
// Motor-drive stage: PWM period counter, per-period duty latching, raw PWM
// compare, over-current period counting and the IDLE/RUN/FAULT sequencer.
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_T      = DEAD_T_DEF,
  parameter int BLANK_T     = BLANK_T_DEF,
  parameter int OVR_I_LIMIT = OVR_I_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  input  logic        clr_fault,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        period_strt,
  output logic        ovr_i_shtdwn
);

  localparam int OC_W = $clog2(OVR_I_LIMIT + 1);
  localparam logic [OC_W-1:0] OC_LIM = OC_W'(OVR_I_LIMIT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_duty_l;
  logic [CNT_W-1:0] r_duty_r;
  logic             r_raw_l;
  logic             r_raw_r;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [OC_W-1:0]  r_ovr_cnt;
  logic [OC_W-1:0]  w_ovr_nxt;
  logic [OC_W-1:0]  w_ovr_inc;
  logic             r_flag;
  logic             w_flag;
  logic             w_qual;
  logic             w_end;
  logic             w_force_off;
  logic             w_hsq_l;
  logic             w_hsq_r;

  assign w_end = (r_cnt == '1);

  // Period counter, duty registers (loaded only at period end) and raw compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_duty_l <= DUTY_MID;
      r_duty_r <= DUTY_MID;
      r_raw_l  <= 1'b0;
      r_raw_r  <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_raw_l <= (r_cnt < r_duty_l);
      r_raw_r <= (r_cnt < r_duty_r);
      if (w_end) begin
        r_duty_l <= spd2duty(lft_spd);
        r_duty_r <= spd2duty(rght_spd);
      end
    end
  end

  // A qualified over-current in the current cycle counts toward this period.
  assign w_qual    = (OVR_I_lft & w_hsq_l) | (OVR_I_rght & w_hsq_r);
  assign w_flag    = r_flag | w_qual;
  assign w_ovr_inc = (r_ovr_cnt < OC_LIM) ? r_ovr_cnt + OC_W'(1) : r_ovr_cnt;

  // Next-state and over-current counter decisions, all taken at period end.
  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_ovr_nxt   = r_ovr_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_end) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_end) begin
          w_ovr_nxt = w_flag ? w_ovr_inc : '0;
          if (w_flag && (w_ovr_inc == OC_LIM)) w_state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (w_end && clr_fault) begin
          w_state_nxt = ST_RUN;
          w_ovr_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, over-current counter and per-period over-current flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ovr_cnt <= '0;
      r_flag    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ovr_cnt <= w_ovr_nxt;
      r_flag    <= w_end ? 1'b0 : w_flag;
    end
  end

  // Gating from the next state lets the registered gate drives drop on the
  // same edge that enters FAULT, rather than one clock later.
  assign w_force_off = (w_state_nxt != ST_RUN);

  pwm_deadtime #(.DEAD_T(DEAD_T), .BLANK_T(BLANK_T)) u_leg_lft (
    .clk       (clk),
    .rst       (rst),
    .pwm_raw   (r_raw_l),
    .force_off (w_force_off),
    .PWM1      (PWM1_lft),
    .PWM2      (PWM2_lft),
    .hs_qual   (w_hsq_l)
  );

  pwm_deadtime #(.DEAD_T(DEAD_T), .BLANK_T(BLANK_T)) u_leg_rght (
    .clk       (clk),
    .rst       (rst),
    .pwm_raw   (r_raw_r),
    .force_off (w_force_off),
    .PWM1      (PWM1_rght),
    .PWM2      (PWM2_rght),
    .hs_qual   (w_hsq_r)
  );

  assign period_strt  = (r_cnt == '0);
  assign ovr_i_shtdwn = (r_state == ST_FAULT);

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: per-period high-time counts of every gate,
// overlap, shutdown and period_strt are compared against a scoreboard queue.
module tb_mtr_drv;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        OVR_I_lft;
  logic        OVR_I_rght;
  logic        clr_fault;
  logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght;
  logic        period_strt;
  logic        ovr_i_shtdwn;

  always #5 clk = ~clk;

  mtr_drv dut (
    .clk          (clk),
    .rst          (rst),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .clr_fault    (clr_fault),
    .PWM1_lft     (PWM1_lft),
    .PWM2_lft     (PWM2_lft),
    .PWM1_rght    (PWM1_rght),
    .PWM2_rght    (PWM2_rght),
    .period_strt  (period_strt),
    .ovr_i_shtdwn (ovr_i_shtdwn)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Expected high-cycle counts over one full 2048-cycle period.
  typedef struct {
    string tag;
    int    l1;
    int    l2;
    int    r1;
    int    r2;
    int    sd;
  } exp_t;

  exp_t sb_q[$];

  task automatic push_exp(input string tag, input int l1, input int l2,
                          input int r1, input int r2, input int sd);
    exp_t e;
    e.tag = tag; e.l1 = l1; e.l2 = l2; e.r1 = r1; e.r2 = r2; e.sd = sd;
    sb_q.push_back(e);
  endtask

  // Advance to the next negedge where period_strt is high, bounded.
  task automatic wait_strt();
    bit found = 1'b0;
    for (int i = 0; i < 4200 && !found; i++) begin
      @(negedge clk);
      if (period_strt) found = 1'b1;
    end
    if (!found) check("strt_timeout", int'(found), 1);
  endtask

  task automatic skip_period();
    wait_strt();
    repeat (2047) @(negedge clk);
  endtask

  // Observe one period (cnt 0..2047) while optionally driving stimulus at
  // given counts, then pop the expected result and compare.
  task automatic measure(input bit aligned, input int ovr_on, input int ovr_off,
                         input int chg_at, input logic [11:0] chg_val,
                         input int clr_at);
    int   l1 = 0, l2 = 0, r1 = 0, r2 = 0, ovl = 0, sd = 0, ps = 0;
    exp_t e;
    if (!aligned) wait_strt();
    for (int c = 0; c < 2048; c++) begin
      if (c > 0) @(negedge clk);
      l1  += int'(PWM1_lft);
      l2  += int'(PWM2_lft);
      r1  += int'(PWM1_rght);
      r2  += int'(PWM2_rght);
      ovl += int'((PWM1_lft & PWM2_lft) | (PWM1_rght & PWM2_rght));
      sd  += int'(ovr_i_shtdwn);
      ps  += int'(period_strt);
      if (c == ovr_on)  OVR_I_lft = 1'b1;
      if (c == ovr_off) OVR_I_lft = 1'b0;
      if (c == chg_at)  rght_spd  = chg_val;
      clr_fault = (c == clr_at);
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".pwm1_l"}, l1, e.l1);
      check({e.tag, ".pwm2_l"}, l2, e.l2);
      check({e.tag, ".pwm1_r"}, r1, e.r1);
      check({e.tag, ".pwm2_r"}, r2, e.r2);
      check({e.tag, ".shtdwn"}, sd, e.sd);
      check({e.tag, ".overlap"}, ovl, 0);
      check({e.tag, ".strt"}, ps, 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".pwm1_l"}, int'(PWM1_lft), 0);
    check({tag, ".pwm2_l"}, int'(PWM2_lft), 0);
    check({tag, ".pwm1_r"}, int'(PWM1_rght), 0);
    check({tag, ".pwm2_r"}, int'(PWM2_rght), 0);
    check({tag, ".shtdwn"}, int'(ovr_i_shtdwn), 0);
    check({tag, ".strt"}, int'(period_strt), 1);
  endtask

  initial begin
    rst        = 1'b1;
    lft_spd    = 12'h000;
    rght_spd   = 12'h000;
    OVR_I_lft  = 1'b0;
    OVR_I_rght = 1'b0;
    clr_fault  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Release in the cnt==0 cycle; the first full period is IDLE.
    rst = 1'b0;
    push_exp("idle", 0, 0, 0, 0, 0);
    measure(1'b1, -1, -1, -1, 12'h000, -1);

    push_exp("run_spd0", 992, 992, 992, 992, 0);
    measure(1'b0, -1, -1, -1, 12'h000, -1);

    lft_spd = 12'h7FF;
    skip_period();
    push_exp("lft_7ff", 2015, 0, 992, 992, 0);
    measure(1'b0, -1, -1, -1, 12'h000, -1);

    lft_spd = 12'h800;
    skip_period();
    push_exp("lft_800", 0, 2048, 992, 992, 0);
    measure(1'b0, -1, -1, -1, 12'h000, -1);

    lft_spd = 12'h000;
    skip_period();

    // Mid-period right command change is invisible until the next period.
    push_exp("r_chg_pre", 992, 992, 992, 992, 0);
    measure(1'b0, -1, -1, 500, 12'h400, -1);
    push_exp("r_chg_post", 992, 992, 1504, 480, 0);
    measure(1'b0, -1, -1, -1, 12'h000, -1);

    // Over-current only inside the blanking window, for more than the limit.
    for (int k = 0; k < 9; k++) begin
      push_exp("blank", 992, 992, 1504, 480, 0);
      measure(1'b0, 40, 130, -1, 12'h000, -1);
    end

    // Sustained over-current: eight periods of RUN, then FAULT.
    OVR_I_lft = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push_exp("ovr_run", 992, 992, 1504, 480, 0);
      measure(1'b0, -1, -1, -1, 12'h000, -1);
    end
    push_exp("fault", 0, 0, 0, 0, 2048);
    measure(1'b0, -1, -1, -1, 12'h000, -1);
    OVR_I_lft = 1'b0;

    // clr_fault away from period end is ignored.
    push_exp("fault_clr100", 0, 0, 0, 0, 2048);
    measure(1'b0, -1, -1, -1, 12'h000, 100);

    // clr_fault at cnt==2047 returns to RUN on the next edge.
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    check("clr_exit.shtdwn", int'(ovr_i_shtdwn), 0);
    check("clr_exit.pwm2_l", int'(PWM2_lft), 1);
    push_exp("recovered", 992, 992, 1504, 480, 0);
    measure(1'b1, -1, -1, -1, 12'h000, -1);

    // Reset mid-RUN.
    repeat (700) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_exp("idle_after_rst", 0, 0, 0, 0, 0);
    measure(1'b1, -1, -1, -1, 12'h000, -1);
    push_exp("run_after_rst", 992, 992, 1504, 480, 0);
    measure(1'b0, -1, -1, -1, 12'h000, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mtr_drv.md
Name: mtr_drv

Overview:
- Downstream motor-drive stage of the Segway datapath.
- Consumes the saturated signed 12-bit lft_spd/rght_spd wheel commands from the steering/deadzone math stage.
- Produces complementary, dead-time-protected PWM pairs for the left and right H-bridges.
- Includes over-current blanking and a latching fault shutdown.

Parameters:
- CNT_W, 11: PWM counter width; period = 2^CNT_W clk cycles (2048).
- DEAD_T, 32: dead-time in clk cycles; both switches of a leg are low for this many cycles after each PWM edge.
- BLANK_T, 128: cycles after high-side turn-on during which OVR_I is ignored.
- OVR_I_LIMIT, 8: number of consecutive PWM periods with a qualified over-current that latches shutdown.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- lft_spd  in  12  signed left command, -2048..2047
- rght_spd  in  12  signed right command
- OVR_I_lft  in  1  left over-current comparator, already synchronized to clk
- OVR_I_rght  in  1  right over-current comparator, already synchronized to clk
- clr_fault  in  1  request to leave FAULT
- PWM1_lft  out  1  left high-side gate
- PWM2_lft  out  1  left low-side gate
- PWM1_rght  out  1  right high-side gate
- PWM2_rght  out  1  right low-side gate
- period_strt  out  1  high while cnt == 0
- ovr_i_shtdwn  out  1  high in FAULT

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. On rst, cnt=0, all PWM outputs=0, ovr_i_shtdwn=0, duty registers=0x400, state=IDLE. Reset mid-period takes effect on the next edge with no completion of the current period.
- PWM counter: cnt is a free-running CNT_W-bit counter, 0..2047, wrapping 2047->0.
- Duty mapping: duty = {~spd[11], spd[10:1]}, i.e. offset binary (spd>>>1)+0x400. Thus spd 0 -> 0x400 (50%), 0x800 -> 0x000, 0x7FF -> 0x7FF.
- Duty latching: duty registers load only in the cycle where cnt==2047. Inputs that change mid-period have no effect until the next period.
- Raw PWM: pwm_raw(t+1) = (cnt(t) < duty(t)). With duty 0, pwm_raw is always 0; with duty 0x7FF, pwm_raw is low for 1 cycle per period.
- Dead-time (per side): an internal counter restarts on every pwm_raw edge and saturates at DEAD_T. Outputs are registered:
  - PWM1 = pwm_raw & (dt_cnt >= DEAD_T).
  - PWM2 = ~pwm_raw & (dt_cnt >= DEAD_T).
  - PWM1 and PWM2 are never both 1.
  - A pwm_raw pulse shorter than DEAD_T drives neither switch.
- Blanking: a per-side on-time counter clears when PWM1 falls. OVR_I_x is qualified only when PWM1_x=1 and on-time >= BLANK_T.
- Fault counting: a period flag is set by any qualified OVR_I on either side. At cnt==2047:
  - If the flag is set, ovr_cnt++; otherwise ovr_cnt clears.
  - The flag then clears.
  - If ovr_cnt reaches OVR_I_LIMIT, the FSM enters FAULT.
- FSM states:
  - IDLE (post-reset): all PWM outputs 0; go to RUN at the first cnt==2047.
  - RUN: PWM outputs driven from the dead-time logic; go to FAULT when ovr_cnt reaches OVR_I_LIMIT.
  - FAULT: all four PWM outputs 0 from the next clk; ovr_i_shtdwn=1; ovr_cnt held. Leave to RUN only when clr_fault=1 at cnt==2047; ovr_cnt clears on exit. clr_fault at any other count is ignored. If clr_fault arrives in the same cycle the limit is reached, FAULT wins.
- period_strt: decoded from cnt==0 in every state.

Decomposition:
- Package mtr_drv_pkg:
  - state enum {IDLE, RUN, FAULT};
  - default constants for DEAD_T, BLANK_T, OVR_I_LIMIT;
  - function spd2duty(12-bit signed) returning the CNT_W-bit duty.
- Sub-module pwm_deadtime (params DEAD_T, BLANK_T):
  - inputs: clk, rst, pwm_raw, force_off.
  - outputs: PWM1, PWM2, hs_qual (PWM1 on-time >= BLANK_T).
  - Instantiated once per side.
- Counter, duty registers, fault counter and FSM stay in mtr_drv.

Test Plan:
- lft_spd=0, no OVR_I, after 2 periods: per 2048-cycle period PWM1_lft high 992 cycles and PWM2_lft high 992 cycles; never both high.
- lft_spd=0x7FF: PWM1_lft high 2015 cycles per period, PWM2_lft 0. lft_spd=0x800: PWM1_lft 0, PWM2_lft high 2048 cycles.
- rght_spd changes 0x000->0x400 at cnt=500: the duty change first appears in the period after the next cnt==2047, with PWM1_rght high 1504 cycles.
- OVR_I_lft pulses only during the first 100 cycles of high-side on-time: never qualified, ovr_i_shtdwn stays 0.
- OVR_I_lft held 1 with lft_spd=0: ovr_i_shtdwn rises after the 8th period's cnt==2047 and all PWM outputs are 0 on the next clk.
- Fault recovery and reset: clr_fault at cnt=100 -> stays in FAULT; at cnt==2047 -> RUN. rst asserted mid-RUN -> all outputs 0 and cnt=0 the next clk; outputs stay 0 for the first full period (IDLE).
